// File: rtl/count_capture_fifo.sv
// Input-capture stage: synchronizes an asynchronous event pin, detects the
// selected edge and snapshots the live counter value into a small FIFO.
module count_capture_fifo #(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [WIDTH-1:0]           count_in,
   input  logic                       cap_evt,
   input  logic                       cap_edge,
   input  logic                       cap_en,
   input  logic                       pop,
   input  logic                       ovf_clr,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       rd_valid,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       ovf
);

   localparam int AW  = $clog2(DEPTH);
   localparam int PW  = AW + 1;
   localparam int WCW = $clog2(SYNC_STAGES + 2);
   localparam logic [WCW-1:0] WARM_DONE = WCW'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic [WCW-1:0]         r_warm_cnt;
   logic [PW-1:0]          r_wr_ptr;
   logic [PW-1:0]          r_rd_ptr;
   logic                   r_ovf;
   logic [WIDTH-1:0]       r_mem [DEPTH];

   logic w_sync;
   logic w_warm_done;
   logic w_rise;
   logic w_fall;
   logic w_hit;
   logic w_empty;
   logic w_full;
   logic w_pop_ok;
   logic w_push_ok;
   logic w_drop;

   assign w_sync      = r_sync[SYNC_STAGES-1];
   assign w_warm_done = (r_warm_cnt == WARM_DONE);
   assign w_rise      = w_sync & ~r_prev;
   assign w_fall      = ~w_sync & r_prev;
   assign w_hit       = w_warm_done & cap_en & (cap_edge ? w_fall : w_rise);

   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop_ok  = pop & ~w_empty;
   // A full FIFO still accepts a capture when the head leaves in the same cycle.
   assign w_push_ok = w_hit & (~w_full | w_pop_ok);
   assign w_drop    = w_hit & w_full & ~pop;

   // NOTE: every sequential block uses non-blocking assignments so all flops
   // update from the same pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync     <= '0;
         r_prev     <= 1'b0;
         r_warm_cnt <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], cap_evt};
         r_prev <= w_sync;
         if (!w_warm_done) r_warm_cnt <= r_warm_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
         // A new drop wins over a simultaneous clear.
         if (w_drop)       r_ovf <= 1'b1;
         else if (ovf_clr) r_ovf <= 1'b0;
      end
   end

   // NOTE: storage has no reset; emptiness comes from the pointers alone, so
   // stale entries are never visible and the array maps onto plain RAM/flops.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= count_in;
   end

   assign rd_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
   assign rd_valid = ~w_empty;
   assign full     = w_full;
   assign level    = r_wr_ptr - r_rd_ptr;
   assign ovf      = r_ovf;

endmodule

// File: tb/tb_count_capture_fifo.sv
// Directed self-checking bench for count_capture_fifo (default parameters).
module tb_count_capture_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] count_in;
   logic       cap_evt;
   logic       cap_edge;
   logic       cap_en;
   logic       pop;
   logic       ovf_clr;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       full;
   logic [2:0] level;
   logic       ovf;

   int n_tests = 0;
   int n_fail  = 0;

   count_capture_fifo dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .count_in (count_in),
      .cap_evt  (cap_evt),
      .cap_edge (cap_edge),
      .cap_en   (cap_en),
      .pop      (pop),
      .ovf_clr  (ovf_clr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .full     (full),
      .level    (level),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive cap_evt to lvl with count_in=v; the write edge is the third tick.
   task automatic evt_edge(input logic [7:0] v, input logic lvl, input int hold,
                           input logic pop_w, input logic clr_w);
      count_in = v;
      cap_evt  = lvl;
      tick();
      tick();
      pop     = pop_w;
      ovf_clr = clr_w;
      tick();
      pop     = 1'b0;
      ovf_clr = 1'b0;
      repeat (hold - 3) tick();
   endtask

   task automatic rise_fall(input logic [7:0] v);
      evt_edge(v, 1'b1, 3, 1'b0, 1'b0);
      evt_edge(8'h00, 1'b0, 3, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cap_evt = 1'b1; cap_edge = 1'b0; cap_en = 1'b1;
      pop = 1'b0; ovf_clr = 1'b0; count_in = 8'h00;
      repeat (3) tick();
      rst_n = 1'b1;
      n_tests++;
      if ({rd_data, rd_valid, full, level, ovf} !== 14'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got data=%0h valid=%0b full=%0b level=%0d ovf=%0b want all 0",
                  rd_data, rd_valid, full, level, ovf);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         n_tests++;
         if (level !== 3'd0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL warmup_cycle%0d: got level=%0d ovf=%0b want 0 0", i, level, ovf);
         end
      end
      cap_evt = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_latency();
      cap_edge = 1'b0; cap_en = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         count_in = 8'(e);
         if (e == 10) cap_evt = 1'b1;
         tick();
         if (e == 11) begin
            n_tests++;
            if (level !== 3'd0) begin
               n_fail++;
               $display("FAIL latency_early: got level=%0d want 0", level);
            end
         end
      end
      n_tests++;
      if (rd_valid !== 1'b1 || level !== 3'd1 || rd_data !== 8'd12) begin
         n_fail++;
         $display("FAIL latency_capture: got valid=%0b level=%0d data=%0d want 1 1 12",
                  rd_valid, level, rd_data);
      end
      pop = 1'b1;
      tick();
      pop = 1'b0;
      n_tests++;
      if (rd_valid !== 1'b0 || rd_data !== 8'h00 || level !== 3'd0) begin
         n_fail++;
         $display("FAIL latency_pop: got valid=%0b data=%0h level=%0d want 0 0 0",
                  rd_valid, rd_data, level);
      end
      cap_evt = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_falling();
      logic [7:0] vals [3];
      vals[0] = 8'h20; vals[1] = 8'h30; vals[2] = 8'h40;
      cap_edge = 1'b1;
      for (int i = 0; i < 3; i++) begin
         evt_edge(8'h11, 1'b1, 5, 1'b0, 1'b0);
         n_tests++;
         if (level !== 3'(i)) begin
            n_fail++;
            $display("FAIL falling_rise_ignored%0d: got level=%0d want %0d", i, level, i);
         end
         evt_edge(vals[i], 1'b0, 5, 1'b0, 1'b0);
      end
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (rd_valid !== 1'b1 || rd_data !== vals[i]) begin
            n_fail++;
            $display("FAIL falling_order%0d: got valid=%0b data=%0h want 1 %0h",
                     i, rd_valid, rd_data, vals[i]);
         end
         pop = 1'b1;
         tick();
         pop = 1'b0;
      end
      n_tests++;
      if (level !== 3'd0) begin
         n_fail++;
         $display("FAIL falling_drained: got level=%0d want 0", level);
      end
      cap_edge = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_overflow();
      logic [7:0] exp_q [4];
      exp_q[0] = 8'hA1; exp_q[1] = 8'hA2; exp_q[2] = 8'hA3; exp_q[3] = 8'hA5;
      for (int i = 0; i < 4; i++) rise_fall(8'hA0 + 8'(i));
      n_tests++;
      if (full !== 1'b1 || level !== 3'd4 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_fill: got full=%0b level=%0d ovf=%0b want 1 4 0", full, level, ovf);
      end
      rise_fall(8'hA4);
      n_tests++;
      if (ovf !== 1'b1 || level !== 3'd4 || rd_data !== 8'hA0) begin
         n_fail++;
         $display("FAIL ovf_drop: got ovf=%0b level=%0d data=%0h want 1 4 a0", ovf, level, rd_data);
      end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      n_tests++;
      if (ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clear: got ovf=%0b want 0", ovf);
      end
      evt_edge(8'hA5, 1'b1, 3, 1'b1, 1'b0);
      n_tests++;
      if (level !== 3'd4 || ovf !== 1'b0 || rd_data !== 8'hA1) begin
         n_fail++;
         $display("FAIL ovf_push_pop_full: got level=%0d ovf=%0b data=%0h want 4 0 a1",
                  level, ovf, rd_data);
      end
      evt_edge(8'h00, 1'b0, 3, 1'b0, 1'b0);
      evt_edge(8'hA6, 1'b1, 3, 1'b0, 1'b1);
      n_tests++;
      if (ovf !== 1'b1 || level !== 3'd4) begin
         n_fail++;
         $display("FAIL ovf_set_wins: got ovf=%0b level=%0d want 1 4", ovf, level);
      end
      evt_edge(8'h00, 1'b0, 3, 1'b0, 1'b0);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (rd_data !== exp_q[i]) begin
            n_fail++;
            $display("FAIL ovf_drain%0d: got data=%0h want %0h", i, rd_data, exp_q[i]);
         end
         pop = 1'b1;
         tick();
         pop = 1'b0;
      end
      pop = 1'b1;
      tick();
      pop = 1'b0;
      n_tests++;
      if (level !== 3'd0 || rd_valid !== 1'b0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL pop_empty_ignored: got level=%0d valid=%0b ovf=%0b want 0 0 0",
                  level, rd_valid, ovf);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 10; i++) begin
         logic [7:0] v;
         v = 8'h50 + 8'(i * 7);
         evt_edge(v, 1'b1, 3, 1'b0, 1'b0);
         n_tests++;
         if (level !== 3'd1 || rd_data !== v) begin
            n_fail++;
            $display("FAIL wrap_push%0d: got level=%0d data=%0h want 1 %0h", i, level, rd_data, v);
         end
         cap_evt = 1'b0;
         pop     = 1'b1;
         tick();
         pop = 1'b0;
         n_tests++;
         if (level !== 3'd0) begin
            n_fail++;
            $display("FAIL wrap_pop%0d: got level=%0d want 0", i, level);
         end
         repeat (2) tick();
      end
   endtask

   task automatic test_enable_and_reset();
      cap_en = 1'b0;
      for (int i = 0; i < 3; i++) rise_fall(8'h55);
      cap_evt = 1'b1;
      repeat (3) tick();
      cap_en = 1'b1;
      repeat (4) tick();
      n_tests++;
      if (level !== 3'd0) begin
         n_fail++;
         $display("FAIL enable_no_capture: got level=%0d want 0", level);
      end
      cap_evt = 1'b0;
      repeat (2) tick();
      for (int i = 0; i < 5; i++) rise_fall(8'h70 + 8'(i));
      pop = 1'b1;
      tick();
      pop = 1'b0;
      n_tests++;
      if (level !== 3'd3 || ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL midfill_setup: got level=%0d ovf=%0b want 3 1", level, ovf);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (level !== 3'd0 || ovf !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
         n_fail++;
         $display("FAIL midfill_reset: got level=%0d ovf=%0b valid=%0b data=%0h want 0 0 0 0",
                  level, ovf, rd_valid, rd_data);
      end
      tick();
      rst_n = 1'b1;
      repeat (4) tick();
      rise_fall(8'h99);
      n_tests++;
      if (level !== 3'd1 || rd_data !== 8'h99) begin
         n_fail++;
         $display("FAIL after_reset_capture: got level=%0d data=%0h want 1 99", level, rd_data);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_falling();
      test_overflow();
      test_wrap();
      test_enable_and_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/count_capture_fifo.md
# count_capture_fifo

Input-capture stage downstream of the 8-bit programmable counter. Watches an asynchronous event pin, synchronizes and edge-detects it, and on each qualifying edge snapshots the counter's current value into a small FIFO. Software/tester drains the FIFO through a pop handshake; overflow is flagged sticky.

## Interface

- WIDTH, 8, width of captured counter value
- DEPTH, 4, FIFO entries; power of two, at least 2
- SYNC_STAGES, 2, synchronizer flops on cap_evt; at least 2
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- count_in  in  WIDTH  live counter value (counter's data output)
- cap_evt  in  1  asynchronous event pin
- cap_edge  in  1  0 = capture on rising edge, 1 = falling edge
- cap_en  in  1  capture enable
- pop  in  1  remove head entry when rd_valid=1
- ovf_clr  in  1  clear sticky overflow
- rd_data  out  WIDTH  head entry; 0 when empty
- rd_valid  out  1  FIFO not empty
- full  out  1  level == DEPTH
- level  out  clog2(DEPTH)+1  current occupancy
- ovf  out  1  sticky: capture dropped while full

## Operation

- Synchronizer: cap_evt through SYNC_STAGES flops → sync; one history flop → prev. All reset to 0.
- Warm-up: edge detection disabled until SYNC_STAGES+1 clocks after rst_n deasserts (small counter, reset 0); prevents spurious edge when cap_evt is high at reset release.
- Edge: rise = sync & ~prev; fall = ~sync & prev; hit = warm-up done & cap_en & (cap_edge ? fall : rise).
- History flop updates every cycle regardless of cap_en/cap_edge; toggling cap_en or cap_edge never creates a capture by itself.
- Push on hit: mem[wr_ptr] <= count_in (value present at that clock edge); wr_ptr++ mod DEPTH.
- Pop when pop & rd_valid: rd_ptr++ mod DEPTH. pop while empty ignored, no state change.
- Pointers carry one extra wrap bit; level = wr_ptr − rd_ptr; full/rd_valid derived from pointers.
- Boundaries:
  - hit & full & pop: both occur, level stays DEPTH, no overflow.
  - hit & full & ~pop: sample dropped, ovf <= 1, pointers unchanged.
  - hit & empty & pop: push only, level 0→1.
  - ovf_clr & new overflow same cycle: ovf stays 1 (set wins).
  - Pointer wrap after DEPTH pushes/pops: transparent, data order preserved.
- rd_data combinational from mem[rd_ptr], forced to 0 when empty. Memory contents need no reset.
- rst_n low mid-operation: immediately empties FIFO, clears ovf, sync/prev, warm-up; in-flight edges lost.

## Timing

- Reset values: rd_data 0, rd_valid 0, full 0, level 0, ovf 0.
- Capture latency: cap_evt transition meeting setup before edge N → sync at edge N+SYNC_STAGES−1 → hit during following cycle → write at edge N+SYNC_STAGES; rd_valid/level update after that edge (3 clocks for SYNC_STAGES=2 from the edge registering stage 1).
- Captured value = count_in at the write edge, not at the pin transition.
- Pop: level/rd_data update after the clock edge sampling pop; throughput one pop per cycle.
- Minimum resolvable event spacing: cap_evt must hold each level ≥ 2 clocks; shorter pulses may be missed (not an error).
- ovf sets after the edge of the dropped push; clears the edge after ovf_clr (absent simultaneous overflow).

## Test plan

- Reset with cap_evt=1, hold rst_n low 3 clocks, release → no capture during warm-up; all outputs 0; level stays 0 for 10 cycles.
- count_in ramps 0,1,2,…; cap_edge=0, cap_en=1; rising cap_evt registered at edge 10 → entry written at edge 12 holds 12 (count_in at that edge); rd_valid=1, level=1; pop → rd_valid=0, rd_data=0.
- cap_edge=1: 3 falling edges spaced 5 cycles, count_in fixed per step 0x20,0x30,0x40 → FIFO reads 0x20,0x30,0x40 in order; rising edges produce nothing.
- Fill 4 entries, 5th edge without pop → full=1, ovf=1, level=4, contents unchanged; 6th edge with pop same cycle → level 4, no extra drop; ovf_clr → ovf 0.
- Wrap: 10 alternating push/pop pairs with distinct values → every value read back once, in order; level never exceeds 1.
- cap_en=0 while cap_evt toggles, then raise cap_en with sync high → no capture; pulse rst_n low mid-fill (level 3) → level 0, ovf 0 immediately.
